gpio_irq_periph: RTL

GPIO_IRQ_PERIPH -- requirements
Module: gpio_irq_periph

---
 rtl/gpio_irq_periph.sv | 90 +++++++++
 1 files changed

// File: rtl/gpio_irq_periph.sv
// gpio_irq_periph: APB GPIO block with per-pin direction, set/reset port and edge-triggered interrupts
module gpio_irq_periph #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [4:0]       PADDR,
    input  logic [31:0]      PWDATA,
    input  logic             PWRITE,
    input  logic             PENABLE,
    input  logic             PSEL,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             irq,
    inout  wire  [WIDTH-1:0] inoutPort
);
    logic [WIDTH-1:0] moder_q, moder_d, odr_q, odr_d, ier_q, ier_d;
    logic [WIDTH-1:0] rtsr_q, rtsr_d, ftsr_q, ftsr_d, isr_q, isr_d;
    logic [WIDTH-1:0] prev_q, idr, ev, wdat, wclr, rdata;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [2:0] addr;
    logic wr, unused_ok;

    assign addr      = PADDR[4:2];
    assign wr        = PSEL & PENABLE & PWRITE;
    assign wdat      = PWDATA[WIDTH-1:0];
    assign wclr      = PWDATA[16 +: WIDTH];
    assign unused_ok = ^{PADDR[1:0], PWDATA};
    assign PREADY    = PSEL & PENABLE;
    assign idr       = sync_q[SYNC_STAGES-1];
    assign ev        = ((idr & ~prev_q & rtsr_q) | (~idr & prev_q & ftsr_q)) & ~moder_q;
    assign irq       = |(isr_q & ier_q);
    assign PRDATA    = (PSEL & ~PWRITE) ? 32'(rdata) : '0;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_pad
        assign inoutPort[i] = moder_q[i] ? odr_q[i] : 1'bz;
    end

    // next-state for the register file; BSRR clear beats set, ISR set beats write-one-clear
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], inoutPort};
        moder_d = (wr && addr == 3'd0) ? wdat : moder_q;
        odr_d   = (wr && addr == 3'd2) ? wdat :
                  (wr && addr == 3'd3) ? (odr_q | wdat) & ~wclr : odr_q;
        ier_d   = (wr && addr == 3'd4) ? wdat : ier_q;
        rtsr_d  = (wr && addr == 3'd5) ? wdat : rtsr_q;
        ftsr_d  = (wr && addr == 3'd6) ? wdat : ftsr_q;
        isr_d   = (isr_q & ~((wr && addr == 3'd7) ? wdat : '0)) | ev;
    end

    // read mux over current register state; BSRR is write-only
    always_comb begin
        rdata = '0;
        case (addr)
            3'd0: rdata = moder_q;
            3'd1: rdata = idr;
            3'd2: rdata = odr_q;
            3'd4: rdata = ier_q;
            3'd5: rdata = rtsr_q;
            3'd6: rdata = ftsr_q;
            3'd7: rdata = isr_q;
            default: rdata = '0;
        endcase
    end

    // state update; async reset clears everything so pins float and irq drops at once
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            moder_q <= '0;
            odr_q   <= '0;
            ier_q   <= '0;
            rtsr_q  <= '0;
            ftsr_q  <= '0;
            isr_q   <= '0;
            prev_q  <= '0;
            sync_q  <= '0;
        end else begin
            moder_q <= moder_d;
            odr_q   <= odr_d;
            ier_q   <= ier_d;
            rtsr_q  <= rtsr_d;
            ftsr_q  <= ftsr_d;
            isr_q   <= isr_d;
            prev_q  <= idr;
            sync_q  <= sync_d;
        end
    end
endmodule
